hub75_scan: RTL and testbench

Row-scan controller for a HUB75-style LED panel. It reads one row pair of 1-bit-per-colour pixel data from a pixel store and shifts it out column by column. It then latches the row, drives the row address and holds the row lit for a fixed on-time. It sits directly upstream of the output inverter: `display_en` is active-high, and the inverter turns it into the panel's active-low OE.

---
 rtl/hub75_scan.sv | 150 +++++++++++++++
 tb/tb_hub75_scan.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/hub75_scan.sv
// Row-scan controller for a HUB75-style LED panel.
// Reads one row pair of 1-bit-per-colour pixels, shifts it out column by
// column, latches it, drives the row address and holds the row lit for a
// fixed on-time. display_en is active-high and feeds the external OE inverter.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for enable; shift_row parked at 0
// SHIFT   | 2*COLS+2 cycles: read pixel, present on rgb, pulse panel_clk
// LATCH   | one-cycle latch strobe; row_addr picks up shift_row
// SETTLE  | one quiet cycle for the row drivers
// DISPLAY | ON_CYCLES cycles with display_en high, then next row or IDLE
module hub75_scan #(
    parameter int COLS      = 64,
    parameter int ROW_BITS  = 4,
    parameter int ON_CYCLES = 256,
    localparam int CW       = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    output logic                   rd_en,
    output logic [ROW_BITS+CW-1:0] rd_addr,
    input  logic [5:0]             rd_data,
    output logic [5:0]             rgb,
    output logic                   panel_clk,
    output logic                   latch,
    output logic [ROW_BITS-1:0]    row_addr,
    output logic                   display_en,
    output logic                   frame_done
);

    localparam int OW = $clog2(ON_CYCLES + 1);
    localparam logic [CW-1:0]       COL_LAST = CW'(COLS - 1);
    localparam logic [ROW_BITS-1:0] ROW_LAST = '1;
    localparam logic [OW-1:0]       ON_LOAD  = OW'(ON_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        LATCH,
        SETTLE,
        DISPLAY
    } state_t;

    state_t state, state_next;

    // SHIFT position: k = 2*col + phase while tail = 0, k = 2*COLS + phase once tail = 1
    logic [CW-1:0]       col;
    logic                phase;
    logic                tail;
    logic [OW-1:0]       on_cnt;
    logic [ROW_BITS-1:0] shift_row;

    logic on_last;
    assign on_last = (on_cnt == '0);

    assign rd_addr = {shift_row, col};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and decoded strobes
    always_comb begin
        state_next = state;
        rd_en      = 1'b0;
        panel_clk  = 1'b0;
        latch      = 1'b0;
        display_en = 1'b0;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                if (enable) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                rd_en = !phase && !tail;
                // first edge comes one pair after column 0 lands on rgb
                panel_clk = phase && (tail || (col != '0));
                if (phase && tail) begin
                    state_next = LATCH;
                end
            end
            LATCH: begin
                latch      = 1'b1;
                state_next = SETTLE;
            end
            SETTLE: begin
                state_next = DISPLAY;
            end
            DISPLAY: begin
                display_en = 1'b1;
                if (on_last) begin
                    frame_done = (shift_row == ROW_LAST);
                    state_next = enable ? SHIFT : IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Column walk, pixel capture, row latch, on-time down-counter and row advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col       <= '0;
            phase     <= 1'b0;
            tail      <= 1'b0;
            on_cnt    <= '0;
            shift_row <= '0;
            rgb       <= '0;
            row_addr  <= '0;
        end else begin
            if (state == SHIFT) begin
                phase <= ~phase;
                if (phase) begin
                    if (tail) begin
                        tail     <= 1'b0;
                        col      <= '0;
                        row_addr <= shift_row;
                    end else begin
                        rgb <= rd_data;
                        if (col == COL_LAST) begin
                            tail <= 1'b1;
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end
            end
            if (state == SETTLE) begin
                on_cnt <= ON_LOAD;
            end else if (state == DISPLAY && !on_last) begin
                on_cnt <= on_cnt - 1'b1;
            end
            if (state == DISPLAY && on_last) begin
                shift_row <= enable ? shift_row + 1'b1 : '0;
            end
        end
    end

endmodule

// File: tb/tb_hub75_scan.sv
// Bench for hub75_scan: random pixel store, a row/position reference model
// and directed steps for reset, frame wrap, enable drop and mid-row reset.
module tb_hub75_scan;

    localparam int C   = 4;
    localparam int RB  = 2;
    localparam int ON  = 8;
    localparam int R   = 1 << RB;
    localparam int P   = 2 * C + 4 + ON;
    localparam int AW  = RB + 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [5:0]    rd_data = 6'h00;
    logic [5:0]    rgb;
    logic          panel_clk;
    logic          latch;
    logic [RB-1:0] row_addr;
    logic          display_en;
    logic          frame_done;

    int errors = 0;
    int checks = 0;

    // reference model: position k within the row period, row, idle flag
    bit         m_idle;
    int         m_k;
    int         m_row;
    logic [5:0] m_rgb;
    int         m_rowaddr;
    logic [5:0] mem [R*C];

    hub75_scan #(.COLS(C), .ROW_BITS(RB), .ON_CYCLES(ON)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .rgb(rgb), .panel_clk(panel_clk), .latch(latch),
        .row_addr(row_addr), .display_en(display_en), .frame_done(frame_done)
    );

    // free-running system clock
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_idle    = 1'b1;
        m_k       = 0;
        m_row     = 0;
        m_rgb     = 6'h00;
        m_rowaddr = 0;
    endtask

    task automatic model_step();
        if (m_idle) begin
            if (enable) begin
                m_idle = 1'b0;
                m_k    = 0;
            end
        end else begin
            if (m_k < 2 * C && m_k % 2 == 1) m_rgb = mem[m_row * C + (m_k - 1) / 2];
            if (m_k + 1 == 2 * C + 2) m_rowaddr = m_row;
            if (m_k == P - 1) begin
                m_k = 0;
                if (enable) begin
                    m_row = (m_row + 1) % R;
                end else begin
                    m_idle = 1'b1;
                    m_row  = 0;
                end
            end else begin
                m_k++;
            end
        end
    endtask

    task automatic compare_all();
        bit e_rd;
        e_rd = !m_idle && m_k < 2 * C && m_k % 2 == 0;
        chk("rd_en", rd_en, e_rd);
        if (e_rd) chk("rd_addr", rd_addr, m_row * C + m_k / 2);
        chk("rgb", rgb, m_rgb);
        chk("panel_clk", panel_clk, !m_idle && m_k % 2 == 1 && m_k >= 3 && m_k <= 2 * C + 1);
        chk("latch", latch, !m_idle && m_k == 2 * C + 2);
        chk("row_addr", row_addr, m_rowaddr);
        chk("display_en", display_en, !m_idle && m_k >= 2 * C + 4);
        chk("frame_done", frame_done, !m_idle && m_k == P - 1 && m_row == R - 1);
    endtask

    task automatic all_zero(input string tag);
        chk({tag, "_rd_en"}, rd_en, 0);
        chk({tag, "_rd_addr"}, rd_addr, 0);
        chk({tag, "_rgb"}, rgb, 0);
        chk({tag, "_panel_clk"}, panel_clk, 0);
        chk({tag, "_latch"}, latch, 0);
        chk({tag, "_row_addr"}, row_addr, 0);
        chk({tag, "_display_en"}, display_en, 0);
        chk({tag, "_frame_done"}, frame_done, 0);
    endtask

    // one clock: check mid-cycle, serve the pixel read, advance the model
    task automatic cycle();
        logic [5:0] nd;
        @(negedge clk);
        compare_all();
        nd = rd_en ? mem[rd_addr] : 6'($urandom);
        model_step();
        @(posedge clk);
        #1 rd_data = nd;
    endtask

    initial begin
        int n;
        for (int i = 0; i < R * C; i++) mem[i] = 6'($urandom);
        model_reset();

        // reset asserted from time 0, checked mid-clock
        #12;
        all_zero("reset");
        #1 rst_n = 1'b1;
        for (int i = 0; i < 20; i++) cycle();

        // two full frames with enable held high
        enable = 1'b1;
        for (int i = 0; i < 2 * P * R + 2; i++) cycle();

        // drop enable during SHIFT of row 1
        n = 0;
        while (!(!m_idle && m_row == 1 && m_k == 3) && n < 200) begin
            cycle();
            n++;
        end
        chk("reach_row1_shift", n < 200, 1);
        enable = 1'b0;
        for (int i = 0; i < P + 10; i++) cycle();
        enable = 1'b1;
        for (int i = 0; i < 2 * P + 5; i++) cycle();

        // reset in the 4th DISPLAY cycle of row 2
        n = 0;
        while (!(!m_idle && m_row == 2 && m_k == 2 * C + 4 + 3) && n < 200) begin
            cycle();
            n++;
        end
        chk("reach_row2_display", n < 200, 1);
        #2;
        chk("pre_reset_display_en", display_en, 1);
        rst_n = 1'b0;
        #1;
        all_zero("midrow_reset");
        model_reset();
        #3 rst_n = 1'b1;
        model_step();
        @(posedge clk);
        #1 rd_data = 6'($urandom);
        for (int i = 0; i < 2 * P; i++) cycle();

        // random enable activity
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 63) == 0) enable = ~enable;
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
